load_execution: RTL and testbench



---
 rtl/load_execution_if.sv | 45 ++++
 rtl/load_execution.sv | 129 ++++++++++++
 tb/tb_load_execution.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_execution_if.sv
// load_execution_if: launch, DRAM read and tile-write signals of the load path.
// Latency: none, wiring only.
// Backpressure: mem_req_ready and vec_write_ready stall the slave side.
interface load_execution_if #(
    parameter int DATA_WIDTH = 8,
    parameter int TILE_WIDTH = 256,
    parameter int TILE_ELEMS = TILE_WIDTH / DATA_WIDTH,
    parameter int ADDR_WIDTH = 24
);
    logic                                         start;
    logic [4:0]                                   dest_buffer_id;
    logic [9:0]                                   length;
    logic [ADDR_WIDTH-1:0]                        addr;
    logic                                         done;

    logic                                         mem_req_valid;
    logic [ADDR_WIDTH-1:0]                        mem_req_addr;
    logic                                         mem_req_ready;
    logic                                         mem_resp_valid;
    logic [DATA_WIDTH-1:0]                        mem_resp_data;

    logic                                         vec_write_enable;
    logic [4:0]                                   vec_write_buffer_id;
    logic [5:0]                                   vec_write_tile_idx;
    logic signed [TILE_ELEMS-1:0][DATA_WIDTH-1:0] vec_write_tile;
    logic                                         vec_write_ready;

    modport master (
        output start, dest_buffer_id, length, addr,
        input  done,
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  vec_write_enable, vec_write_buffer_id, vec_write_tile_idx, vec_write_tile,
        output vec_write_ready
    );

    modport slave (
        input  start, dest_buffer_id, length, addr,
        output done,
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output vec_write_enable, vec_write_buffer_id, vec_write_tile_idx, vec_write_tile,
        input  vec_write_ready
    );
endinterface

// File: rtl/load_execution.sv
// load_execution: reads a length-element int8 vector from DRAM and writes it as zero-padded tiles.
// Latency: first request 1 cycle after start; 2 cycles + memory latency per element; done 1 cycle after last tile write.
// Backpressure: request held stable until mem_req_ready, tile held stable until vec_write_ready; one byte outstanding.
module load_execution #(
    parameter int DATA_WIDTH = 8,
    parameter int TILE_WIDTH = 256,
    parameter int TILE_ELEMS = TILE_WIDTH / DATA_WIDTH,
    parameter int ADDR_WIDTH = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    load_execution_if.slave bus
);
    localparam int EW = (TILE_ELEMS > 1) ? $clog2(TILE_ELEMS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_RESP,
        WRITE_TILE,
        COMPLETE
    } state_t;

    state_t                                       state;
    state_t                                       state_n;

    logic [9:0]                                   len_q;
    logic [ADDR_WIDTH-1:0]                        base_q;
    logic [4:0]                                   buf_q;
    logic [9:0]                                   count_q;
    logic [EW-1:0]                                elem_q;
    logic [5:0]                                   tile_idx_q;
    logic signed [TILE_ELEMS-1:0][DATA_WIDTH-1:0] tile_q;
    logic                                         tile_full;

    // The tile closes either when it is full or when the vector runs out; count_q < len_q here.
    assign tile_full = (elem_q == EW'(TILE_ELEMS - 1)) || ((count_q + 10'd1) == len_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = (bus.length == 10'd0) ? COMPLETE : REQ;
                end
            end
            REQ: begin
                if (bus.mem_req_ready) begin
                    state_n = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (bus.mem_resp_valid) begin
                    state_n = tile_full ? WRITE_TILE : REQ;
                end
            end
            WRITE_TILE: begin
                if (bus.vec_write_ready) begin
                    state_n = (count_q == len_q) ? COMPLETE : REQ;
                end
            end
            COMPLETE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q      <= '0;
            base_q     <= '0;
            buf_q      <= '0;
            count_q    <= '0;
            elem_q     <= '0;
            tile_idx_q <= '0;
            tile_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        len_q      <= bus.length;
                        base_q     <= bus.addr;
                        buf_q      <= bus.dest_buffer_id;
                        count_q    <= '0;
                        elem_q     <= '0;
                        tile_idx_q <= '0;
                        tile_q     <= '0;
                    end
                end
                WAIT_RESP: begin
                    if (bus.mem_resp_valid) begin
                        tile_q[elem_q] <= bus.mem_resp_data;
                        count_q        <= count_q + 10'd1;
                        elem_q         <= elem_q + EW'(1);
                    end
                end
                WRITE_TILE: begin
                    // Clearing here is what zero-pads a short final tile.
                    if (bus.vec_write_ready) begin
                        tile_q     <= '0;
                        elem_q     <= '0;
                        tile_idx_q <= tile_idx_q + 6'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.done                = (state == COMPLETE);
    assign bus.mem_req_valid       = (state == REQ);
    assign bus.mem_req_addr        = base_q + ADDR_WIDTH'(count_q);
    assign bus.vec_write_enable    = (state == WRITE_TILE);
    assign bus.vec_write_buffer_id = buf_q;
    assign bus.vec_write_tile_idx  = tile_idx_q;
    assign bus.vec_write_tile      = tile_q;
endmodule

// File: tb/tb_load_execution.sv
// Bench for load_execution: DRAM and buffer responders plus a vector-level reference model.
`timescale 1ns/1ps
module tb_load_execution;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    load_execution_if bus ();

    load_execution dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit           req_stall = 1'b0;
    int           wr_delay  = 0;
    int           resp_lat  = 2;
    logic [23:0]  req_log[$];
    int           resp_due[$];
    logic [7:0]   resp_dat[$];
    logic [255:0] wr_tile_log[$];
    logic [5:0]   wr_idx_log[$];
    logic [4:0]   wr_buf_log[$];
    int           last_wr_cyc    = 0;
    int           done_cnt       = 0;
    int           req_vld_cycles = 0;
    int           wen_cycles     = 0;
    int           stab_err       = 0;
    int           wen_run        = 0;
    bit           req_hold       = 1'b0;
    bit           wr_hold        = 1'b0;
    logic [23:0]  hold_addr;
    logic [255:0] hold_tile;
    logic [5:0]   hold_idx;
    logic [4:0]   hold_buf;

    // Memory and buffer responders; everything here acts on the falling edge.
    initial begin
        bus.mem_req_ready   = 1'b0;
        bus.mem_resp_valid  = 1'b0;
        bus.mem_resp_data   = '0;
        bus.vec_write_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.mem_resp_valid = 1'b0;
            if (resp_due.size() > 0 && resp_due[0] <= cyc) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data  = resp_dat[0];
                resp_due.delete(0);
                resp_dat.delete(0);
            end
            if (req_hold && (!bus.mem_req_valid || bus.mem_req_addr !== hold_addr)) stab_err++;
            bus.mem_req_ready = req_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (bus.mem_req_valid) req_vld_cycles++;
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                req_log.push_back(bus.mem_req_addr);
                resp_due.push_back(cyc + resp_lat);
                resp_dat.push_back(bus.mem_req_addr[7:0]);
            end
            req_hold  = bus.mem_req_valid && !bus.mem_req_ready;
            hold_addr = bus.mem_req_addr;

            if (wr_hold && (!bus.vec_write_enable || bus.vec_write_tile !== hold_tile ||
                            bus.vec_write_tile_idx !== hold_idx || bus.vec_write_buffer_id !== hold_buf))
                stab_err++;
            if (bus.vec_write_enable) begin
                wen_run++;
                wen_cycles++;
            end else begin
                wen_run = 0;
            end
            bus.vec_write_ready = (wr_delay == 0) ? 1'b1 : (wen_run > wr_delay);
            if (bus.vec_write_enable && bus.vec_write_ready) begin
                wr_tile_log.push_back(bus.vec_write_tile);
                wr_idx_log.push_back(bus.vec_write_tile_idx);
                wr_buf_log.push_back(bus.vec_write_buffer_id);
                last_wr_cyc = cyc;
            end
            wr_hold   = bus.vec_write_enable && !bus.vec_write_ready;
            hold_tile = bus.vec_write_tile;
            hold_idx  = bus.vec_write_tile_idx;
            hold_buf  = bus.vec_write_buffer_id;
            if (bus.done) done_cnt++;
        end
    end

    bit first_valid, first_done, done_after, timed_out;
    int op_done_cyc;

    // Called on a falling edge; launches one op and returns on the falling edge after done.
    task automatic do_op(input logic [23:0] a, input logic [9:0] l, input logic [4:0] b, input bit mid_start);
        bit seen;
        req_log.delete();
        wr_tile_log.delete();
        wr_idx_log.delete();
        wr_buf_log.delete();
        done_cnt       = 0;
        req_vld_cycles = 0;
        wen_cycles     = 0;
        bus.start          = 1'b1;
        bus.addr           = a;
        bus.length         = l;
        bus.dest_buffer_id = b;
        @(negedge clk);
        bus.start          = 1'b0;
        bus.addr           = 24'($urandom);
        bus.length         = 10'($urandom_range(1, 1023));
        bus.dest_buffer_id = 5'($urandom);
        first_valid = bus.mem_req_valid;
        first_done  = bus.done;
        seen        = bus.done;
        op_done_cyc = cyc;
        timed_out   = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            bus.start = mid_start && (i == 25);
            @(negedge clk);
            seen        = bus.done;
            op_done_cyc = cyc;
        end
        bus.start = 1'b0;
        if (!seen) timed_out = 1'b1;
        @(negedge clk);
        done_after = bus.done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.addr = '0;
        bus.length = '0;
        bus.dest_buffer_id = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.done, bus.mem_req_valid, bus.vec_write_enable, bus.mem_req_addr,
             bus.vec_write_buffer_id, bus.vec_write_tile_idx, bus.vec_write_tile} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: done=%b req_vld=%b wen=%b addr=%h buf=%0d idx=%0d, required all 0",
                     bus.done, bus.mem_req_valid, bus.vec_write_enable, bus.mem_req_addr,
                     bus.vec_write_buffer_id, bus.vec_write_tile_idx);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_transfer(input string name, input logic [23:0] a, input logic [9:0] l,
                                 input logic [4:0] b, input bit stall, input int delay, input bit mid);
        int nt;
        req_stall = stall;
        wr_delay  = delay;
        stab_err  = 0;
        do_op(a, l, b, mid);
        nt = (int'(l) + 31) / 32;
        n_checks++;
        if (timed_out) begin
            n_fail++;
            $display("FAIL %s timeout: done not seen, required within 5000 cycles", name);
        end
        n_checks++;
        if (first_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s first_req_latency: req_valid=%b in cycle 1, required 1", name, first_valid);
        end
        n_checks++;
        if (done_after !== 1'b0 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL %s done_pulse: pulses=%0d trailing=%b, required 1 pulse of 1 cycle", name, done_cnt, done_after);
        end
        n_checks++;
        if (req_log.size() !== int'(l)) begin
            n_fail++;
            $display("FAIL %s req_count: got %0d, required %0d", name, req_log.size(), l);
        end
        for (int i = 0; i < req_log.size() && i < int'(l); i++) begin
            logic [23:0] ea;
            ea = a + 24'(i);
            n_checks++;
            if (req_log[i] !== ea) begin
                n_fail++;
                $display("FAIL %s req_addr[%0d]: got %h, required %h", name, i, req_log[i], ea);
            end
        end
        n_checks++;
        if (wr_tile_log.size() !== nt) begin
            n_fail++;
            $display("FAIL %s tile_writes: got %0d, required %0d", name, wr_tile_log.size(), nt);
        end
        for (int t = 0; t < wr_tile_log.size() && t < nt; t++) begin
            logic [255:0] et;
            et = '0;
            for (int e = 0; e < 32; e++) begin
                int k;
                logic [23:0] ea;
                k  = t * 32 + e;
                ea = a + 24'(k);
                if (k < int'(l)) et[e*8 +: 8] = ea[7:0];
            end
            n_checks++;
            if (wr_tile_log[t] !== et || wr_idx_log[t] !== 6'(t) || wr_buf_log[t] !== b) begin
                n_fail++;
                $display("FAIL %s tile[%0d]: idx=%0d buf=%0d data=%h, required idx=%0d buf=%0d data=%h",
                         name, t, wr_idx_log[t], wr_buf_log[t], wr_tile_log[t], t, b, et);
            end
        end
        n_checks++;
        if (op_done_cyc !== last_wr_cyc + 1) begin
            n_fail++;
            $display("FAIL %s done_timing: done in cycle %0d, required %0d", name, op_done_cyc, last_wr_cyc + 1);
        end
        n_checks++;
        if (stab_err !== 0) begin
            n_fail++;
            $display("FAIL %s stall_stability: %0d changes during stalls, required 0", name, stab_err);
        end
    endtask

    task automatic test_zero_length();
        req_stall = 1'b0;
        wr_delay  = 0;
        do_op(24'h00ABCD, 10'd0, 5'd4, 1'b0);
        n_checks++;
        if (first_done !== 1'b1 || done_after !== 1'b0 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL zero_len_done: cycle1=%b trailing=%b pulses=%0d, required 1 0 1", first_done, done_after, done_cnt);
        end
        n_checks++;
        if (req_vld_cycles !== 0 || wen_cycles !== 0) begin
            n_fail++;
            $display("FAIL zero_len_activity: req_vld cycles=%0d wen cycles=%0d, required 0 0", req_vld_cycles, wen_cycles);
        end
    endtask

    task automatic test_reset_abort();
        req_stall = 1'b0;
        wr_delay  = 0;
        resp_lat  = 5;
        done_cnt  = 0;
        req_vld_cycles = 0;
        bus.start = 1'b1;
        bus.addr = 24'h002000;
        bus.length = 10'd10;
        bus.dest_buffer_id = 5'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if ({bus.done, bus.mem_req_valid, bus.vec_write_enable, bus.mem_req_addr,
             bus.vec_write_buffer_id, bus.vec_write_tile_idx, bus.vec_write_tile} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: done=%b req_vld=%b wen=%b addr=%h buf=%0d idx=%0d, required all 0",
                     bus.done, bus.mem_req_valid, bus.vec_write_enable, bus.mem_req_addr,
                     bus.vec_write_buffer_id, bus.vec_write_tile_idx);
        end
        repeat (8) @(negedge clk);
        n_checks++;
        if (done_cnt !== 0 || req_vld_cycles !== 1 || resp_due.size() !== 0 || bus.vec_write_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_quiet: done=%0d req_vld cycles=%0d pending=%0d wen=%b, required 0 1 0 0",
                     done_cnt, req_vld_cycles, resp_due.size(), bus.vec_write_enable);
        end
        resp_lat = 2;
        test_transfer("after_abort", 24'h003000, 10'd3, 5'd12, 1'b0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_transfer("full_tile", 24'h000100, 10'd32, 5'd2, 1'b0, 0, 1'b0);
        test_transfer("short_pad", 24'h000400, 10'd5, 5'd7, 1'b0, 0, 1'b0);
        test_zero_length();
        test_transfer("stall_70", 24'h001234, 10'd70, 5'd9, 1'b1, 3, 1'b1);
        test_transfer("addr_wrap", 24'hFFFFFE, 10'd4, 5'd1, 1'b0, 0, 1'b0);
        test_reset_abort();
        for (int r = 0; r < 4; r++) begin
            test_transfer("random", 24'($urandom), 10'($urandom_range(1, 100)), 5'($urandom),
                          1'b1, $urandom_range(0, 3), 1'b0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
